// File: rtl/counter_seq_ctrl_if.sv
// Handshake/bus bundle between the lab control logic, the sequencing
// controller and the counter datapath. The controller uses the slave view;
// the surrounding environment (lab control plus counter) uses the master view.
interface counter_seq_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int VAL_W = 4
);
  // Command side
  logic             Start;
  logic             Abort;
  logic [VAL_W-1:0] Preset;
  logic [VAL_W-1:0] Target;
  logic [CNT_W-1:0] Max_steps;
  // Counter feedback (decoded counter output)
  logic [VAL_W-1:0] Count_val;
  // Counter control
  logic             Load;
  logic [VAL_W-1:0] Data;
  logic             Step;
  // Status
  logic             Busy;
  logic             Done;
  logic             Timeout;
  logic [CNT_W-1:0] Steps;

  // Environment view: drives commands and reports the counter value.
  modport master (
    output Start, Abort, Preset, Target, Max_steps, Count_val,
    input  Load, Data, Step, Busy, Done, Timeout, Steps
  );

  // Controller view.
  modport slave (
    input  Start, Abort, Preset, Target, Max_steps, Count_val,
    output Load, Data, Step, Busy, Done, Timeout, Steps
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the loadable counter datapath: presets the
// counter, steps it until its decoded output matches a target, and reports
// Done, or Timeout when the step budget runs out first.
module counter_seq_ctrl #(
  parameter int CNT_W = 4,
  parameter int VAL_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  counter_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] preset_q;
  logic [VAL_W-1:0] target_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] steps_q;
  logic             done_q;
  logic             timeout_q;

  logic             hit;
  logic             spent;

  // Run-state termination conditions against the latched operands.
  assign hit   = (bus.Count_val == target_q);
  assign spent = (steps_q == max_q);

  // Decoded outputs: combinational from current state so the counter sees
  // Load/Step in the same cycle the controller is in LOAD/RUN.
  assign bus.Load    = (state == LOAD);
  assign bus.Busy    = (state == LOAD) || (state == RUN);
  assign bus.Step    = (state == RUN) && !bus.Abort && !hit && !spent;
  assign bus.Data    = preset_q;
  assign bus.Done    = done_q;
  assign bus.Timeout = timeout_q;
  assign bus.Steps   = steps_q;

  // Control FSM with operand latches, step counter and registered
  // Done/Timeout pulses.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      preset_q  <= '0;
      target_q  <= '0;
      max_q     <= '0;
      steps_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Pulses default low; only the RUN->FIN transition raises one.
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            preset_q <= bus.Preset;
            target_q <= bus.Target;
            max_q    <= bus.Max_steps;
            steps_q  <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          state <= bus.Abort ? IDLE : RUN;
        end
        RUN: begin
          // Abort beats a match, a match beats an exhausted budget.
          if (bus.Abort) begin
            state <= IDLE;
          end else if (hit) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else if (spent) begin
            state     <= FIN;
            timeout_q <= 1'b1;
          end else begin
            steps_q <= steps_q + 1'b1;
          end
        end
        FIN: begin
          // Start is deliberately ignored here; no command queuing.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural +1 mod 16 counter
// closing the loop on Load/Data/Step -> Count_val.
module tb_counter_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter_seq_ctrl_if #(.CNT_W(4), .VAL_W(4)) bus ();

  counter_seq_ctrl #(.CNT_W(4), .VAL_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural counter datapath.
  logic [3:0] cnt = 4'd0;
  always @(posedge clk) begin
    if (bus.Load)      cnt <= bus.Data;
    else if (bus.Step) cnt <= cnt + 4'd1;
  end
  assign bus.Count_val = cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-operation observations, cycle numbers relative to the Start edge k
  // (cycle 1 == cycle k+1).
  int load_cnt, load_c, step_cnt, done_cnt, done_c, to_cnt, to_c, busy_last;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one Start with the given operands and watch ncyc cycles.
  // abort_c / start_c: cycle in which Abort / a stray Start is raised (0 = never).
  task automatic run_op(input logic [3:0] p, input logic [3:0] t,
                        input logic [3:0] m, input int abort_c,
                        input int start_c, input int ncyc);
    load_cnt = 0; load_c = 0; step_cnt = 0; done_cnt = 0; done_c = 0;
    to_cnt = 0; to_c = 0; busy_last = 0;
    bus.Preset = p; bus.Target = t; bus.Max_steps = m;
    bus.Start = 1'b1; bus.Abort = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.Start  = (c == start_c);
      bus.Abort  = (c == abort_c);
      // A stray Start carries different operands; they must not be latched.
      bus.Target = (c == start_c) ? ~t : t;
      bus.Preset = (c == start_c) ? ~p : p;
      #1;
      if (bus.Load)    begin load_cnt++; load_c = c; end
      if (bus.Step)    step_cnt++;
      if (bus.Done)    begin done_cnt++; if (done_c == 0) done_c = c; end
      if (bus.Timeout) begin to_cnt++;   if (to_c == 0)   to_c = c;   end
      if (bus.Busy)    busy_last = c;
    end
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
  endtask

  initial begin
    bus.Start = 1'b0; bus.Abort = 1'b0;
    bus.Preset = 4'd0; bus.Target = 4'd0; bus.Max_steps = 4'd0;

    // Power-on reset.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_load",    int'(bus.Load),    0);
    check("rst_step",    int'(bus.Step),    0);
    check("rst_busy",    int'(bus.Busy),    0);
    check("rst_done",    int'(bus.Done),    0);
    check("rst_timeout", int'(bus.Timeout), 0);
    check("rst_steps",   int'(bus.Steps),   0);
    check("rst_data",    int'(bus.Data),    0);

    // Reset mid-RUN after two steps.
    bus.Preset = 4'd6; bus.Target = 4'd10; bus.Max_steps = 4'd15;
    bus.Start = 1'b1;
    tick();                                   // cycle 1 (LOAD)
    bus.Start = 1'b0;
    check("mid_load", int'(bus.Load), 1);
    tick(); tick(); tick();                   // cycle 4, two steps issued
    check("mid_steps_before", int'(bus.Steps), 2);
    check("mid_busy_before",  int'(bus.Busy),  1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",  int'(bus.Busy),  0);
    check("mid_rst_step",  int'(bus.Step),  0);
    check("mid_rst_load",  int'(bus.Load),  0);
    check("mid_rst_steps", int'(bus.Steps), 0);
    check("mid_rst_data",  int'(bus.Data),  0);
    check("mid_rst_done",  int'(bus.Done) | int'(bus.Timeout), 0);
    tick();

    // Preset=3, Target=7, budget 15: four steps, Done at k+7.
    run_op(4'd3, 4'd7, 4'd15, 0, 0, 10);
    check("m4_load_c",   load_c,   1);
    check("m4_load_cnt", load_cnt, 1);
    check("m4_steps_hi", step_cnt, 4);
    check("m4_done_c",   done_c,   7);
    check("m4_done_cnt", done_cnt, 1);
    check("m4_timeout",  to_cnt,   0);
    check("m4_steps",    int'(bus.Steps), 4);
    check("m4_idle",     int'(bus.Busy),  0);

    // Preset == Target: Done at k+3 with no steps.
    run_op(4'd5, 4'd5, 4'd4, 0, 0, 6);
    check("eq_done_c",   done_c,   3);
    check("eq_steps_hi", step_cnt, 0);
    check("eq_steps",    int'(bus.Steps), 0);
    check("eq_timeout",  to_cnt,   0);

    // Budget 3 with unreachable target: Timeout at k+6.
    run_op(4'd2, 4'd9, 4'd3, 0, 0, 8);
    check("to_steps_hi", step_cnt, 3);
    check("to_c",        to_c,     6);
    check("to_cnt",      to_cnt,   1);
    check("to_steps",    int'(bus.Steps), 3);
    check("to_done",     done_cnt, 0);

    // Zero budget, no match: Timeout at k+3, nothing issued.
    run_op(4'd4, 4'd6, 4'd0, 0, 0, 6);
    check("z_to_c",     to_c,     3);
    check("z_steps_hi", step_cnt, 0);
    check("z_steps",    int'(bus.Steps), 0);
    check("z_done",     done_cnt, 0);

    // Zero budget with immediate match: Done wins over budget.
    run_op(4'd8, 4'd8, 4'd0, 0, 0, 6);
    check("zm_done_c", done_c, 3);
    check("zm_to",     to_cnt, 0);

    // Abort in the cycle Count_val first equals Target (1 -> 3, cycle 4).
    run_op(4'd1, 4'd3, 4'd15, 4, 0, 8);
    check("ab_done",      done_cnt,  0);
    check("ab_timeout",   to_cnt,    0);
    check("ab_steps_hi",  step_cnt,  2);
    check("ab_busy_last", busy_last, 4);
    check("ab_steps",     int'(bus.Steps), 2);

    // Stray Start during RUN: latched target kept, Done at k+5.
    run_op(4'd0, 4'd2, 4'd15, 0, 3, 9);
    check("sr_done_c",   done_c,   5);
    check("sr_done_cnt", done_cnt, 1);
    check("sr_load_cnt", load_cnt, 1);
    check("sr_timeout",  to_cnt,   0);

    // Stray Start during FIN (cycle 5): no new operation.
    run_op(4'd0, 4'd2, 4'd15, 0, 5, 10);
    check("sf_done_cnt", done_cnt, 1);
    check("sf_load_cnt", load_cnt, 1);
    check("sf_busy_last", busy_last, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the loadable 3-bit-state counter datapath (encoder / adder / register / decoder chain). On a Start command it presets the counter through its Load port, advances it one step per cycle via a step enable until the decoded output equals a target value, then reports Done. If the target is not reached within a programmable step budget it reports Timeout. It sits between the lab control logic and the counter, and owns the counter's Load, Data and step-enable inputs.

## Interface
- CNT_W, 4: width of the step budget and step counter
- VAL_W, 4: width of counter values (Preset, Target, Count_val, Data)

- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- Start  in  1  command; sampled only in IDLE
- Abort  in  1  cancels an operation in LOAD/RUN
- Preset  in  VAL_W  value to load; latched on accepted Start
- Target  in  VAL_W  stop value; latched on accepted Start
- Max_steps  in  CNT_W  step budget; latched on accepted Start
- Count_val  in  VAL_W  counter decoded output (Data_out of counter)
- Load  out  1  counter load strobe
- Data  out  VAL_W  preset value driven to counter (latched Preset)
- Step  out  1  counter advance enable; one advance per cycle high
- Busy  out  1  high in LOAD and RUN
- Done  out  1  one-cycle pulse: target reached
- Timeout  out  1  one-cycle pulse: budget exhausted without match
- Steps  out  CNT_W  number of Step cycles issued in current/last operation

## Operation
- States: IDLE, LOAD, RUN, FIN.
- IDLE: Start=1 -> latch Preset/Target/Max_steps, clear Steps to 0, go LOAD. Otherwise stay.
- LOAD: Load=1, Data=latched preset. Abort=1 -> IDLE (Load still high this cycle). Else -> RUN.
- RUN, evaluated every cycle, priority order:
  1. Abort=1 -> IDLE; Step=0; no Done/Timeout.
  2. Count_val == Target -> FIN with Done set; Step=0.
  3. Steps == Max_steps -> FIN with Timeout set; Step=0.
  4. Else Step=1, Steps <= Steps+1, stay RUN.
- FIN: Done or Timeout high for exactly this cycle (registered, mutually exclusive); -> IDLE unconditionally. Start in FIN ignored.
- Start while Busy or in FIN is ignored; no queuing.
- Load, Step, Busy are decoded from current state (Step also from Count_val/Abort), no extra register stage.
- Steps holds its final value from FIN until the next accepted Start; never exceeds Max_steps, never wraps.
- Max_steps=0: first RUN cycle ends in Done if Count_val==Target, else Timeout; zero steps issued.
- Preset not in the counter's encodable sequence or Target unreachable -> terminates by Timeout.
- RST=1 in any state -> IDLE next edge; latched registers and Steps cleared to 0.

## Timing
- Reset values: Load=0, Data=0, Step=0, Busy=0, Done=0, Timeout=0, Steps=0.
- Start accepted at edge k (IDLE) -> LOAD during cycle k+1 -> RUN from cycle k+2.
- Counter loads at end of LOAD; Count_val shows preset in first RUN cycle.
- Step high in cycle n -> counter advances at end of n; new Count_val compared in cycle n+1.
- Preset==Target: Done in cycle k+3, Steps=0. Match after m steps: Done in cycle k+3+m.
- Timeout with budget M: Timeout in cycle k+3+M, Steps=M.
- Minimum Start-to-Start spacing: 4 cycles (IDLE re-entered the cycle after FIN).
- Abort and match in same RUN cycle: Abort wins.

## Test plan
- Reset mid-RUN (RST=1 after 2 steps) -> next cycle all outputs 0, state IDLE; following Start works normally.
- Behavioral counter model (+1 mod 16), Preset=3, Target=7, Max_steps=15 -> Load pulse cycle k+1, Step high 4 cycles, Done in cycle k+7, Steps=4, Timeout never high.
- Preset=5, Target=5 -> Done in cycle k+3, Step never high, Steps=0.
- Preset=2, Target=9, Max_steps=3 -> Step high 3 cycles, Timeout in cycle k+6, Steps=3, Done never high.
- Abort asserted in the cycle Count_val first equals Target -> returns IDLE, no Done/Timeout pulse, Busy drops next cycle.
- Start pulsed during RUN and during FIN -> ignored: latched Target unchanged, exactly one Done per accepted Start.
